tlb_lookup_engine: RTL and testbench

//  Page-table translation responder. Serves addresses the direct/DMW translator flags as

---
 rtl/tlb_lookup_engine.sv | 187 ++++++++++++++++++
 tb/tb_tlb_lookup_engine.sv | 387 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tlb_lookup_engine.sv
// Page-table translation responder: sequential TLB search, one entry per cycle,
// returning PA, MAT and exception code over a valid/ready handshake.
module tlb_lookup_engine #(
  parameter  int TLBNUM = 16,
  localparam int IDXW   = $clog2(TLBNUM)
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [31:0]     req_va_i,
  input  logic [9:0]      req_asid_i,
  input  logic [1:0]      req_plv_i,
  input  logic [1:0]      req_op_i,
  output logic            resp_valid_o,
  input  logic            resp_ready_i,
  output logic [31:0]     resp_pa_o,
  output logic [1:0]      resp_mat_o,
  output logic            resp_exc_o,
  output logic [5:0]      resp_ecode_o,
  input  logic            wr_en_i,
  input  logic [IDXW-1:0] wr_index_i,
  input  logic [83:0]     wr_data_i,
  input  logic            inv_all_i,
  input  logic [IDXW-1:0] rd_index_i,
  output logic [83:0]     rd_data_o
);

  typedef enum logic [1:0] {S_IDLE, S_SEARCH, S_RESP} state_e;

  localparam logic [5:0] EC_TLBR = 6'h3F;
  localparam logic [5:0] EC_PIF  = 6'h03;
  localparam logic [5:0] EC_PIL  = 6'h01;
  localparam logic [5:0] EC_PIS  = 6'h02;
  localparam logic [5:0] EC_PPI  = 6'h07;
  localparam logic [5:0] EC_PME  = 6'h04;

  // Entry body kept apart from the enable bit so only the e bits need a reset.
  logic [82:0]       ent_q [TLBNUM];
  logic [TLBNUM-1:0] e_q;

  always_ff @(posedge clk_i) begin
    if (wr_en_i && !inv_all_i) begin
      ent_q[wr_index_i] <= wr_data_i[82:0];
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      e_q <= '0;
    end else if (inv_all_i) begin
      e_q <= '0;
    end else if (wr_en_i) begin
      e_q[wr_index_i] <= wr_data_i[83];
    end
  end

  assign rd_data_o = {e_q[rd_index_i], ent_q[rd_index_i]};

  state_e          state_q;
  logic [IDXW-1:0] idx_q;
  logic [31:0]     va_q;
  logic [9:0]      asid_q;
  logic [1:0]      plv_q;
  logic [1:0]      op_q;
  logic            req_ready_q;
  logic            resp_valid_q;
  logic [31:0]     resp_pa_q;
  logic [1:0]      resp_mat_q;
  logic            resp_exc_q;
  logic [5:0]      resp_ecode_q;

  // Compare of the entry under the search pointer.
  logic [83:0] cur_ent;
  logic [18:0] c_vppn;
  logic        c_ps4m;
  logic        c_g;
  logic [9:0]  c_asid;
  logic        vpn_match;
  logic        odd_sel;
  logic [25:0] half;
  logic        hit_d;
  logic [31:0] pa_d;
  logic [1:0]  mat_d;
  logic        exc_d;
  logic [5:0]  ecode_d;
  logic        is_fetch;
  logic        is_store;

  always_comb begin
    cur_ent   = {e_q[idx_q], ent_q[idx_q]};
    c_vppn    = cur_ent[82:64];
    c_ps4m    = cur_ent[63];
    c_g       = cur_ent[62];
    c_asid    = cur_ent[61:52];
    vpn_match = c_ps4m ? (c_vppn[18:9] == va_q[31:22]) : (c_vppn == va_q[31:13]);
    hit_d     = cur_ent[83] & (c_g | (c_asid == asid_q)) & vpn_match;
    odd_sel   = c_ps4m ? va_q[21] : va_q[12];
    half      = odd_sel ? cur_ent[25:0] : cur_ent[51:26];
    // A 4MB page keeps only ppn[19:10]; va supplies the low 22 bits.
    pa_d      = c_ps4m ? {half[25:16], va_q[21:0]} : {half[25:6], va_q[11:0]};
    mat_d     = half[3:2];
    is_fetch  = (op_q == 2'd0);
    is_store  = (op_q == 2'd2);
    exc_d     = 1'b1;
    ecode_d   = 6'h00;
    if (!half[0]) begin
      ecode_d = is_fetch ? EC_PIF : (is_store ? EC_PIS : EC_PIL);
    end else if (plv_q > half[5:4]) begin
      ecode_d = EC_PPI;
    end else if (is_store && !half[1]) begin
      ecode_d = EC_PME;
    end else begin
      exc_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      va_q         <= '0;
      asid_q       <= '0;
      plv_q        <= '0;
      op_q         <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_pa_q    <= '0;
      resp_mat_q   <= '0;
      resp_exc_q   <= 1'b0;
      resp_ecode_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid_i) begin
            va_q        <= req_va_i;
            asid_q      <= req_asid_i;
            plv_q       <= req_plv_i;
            op_q        <= req_op_i;
            idx_q       <= '0;
            req_ready_q <= 1'b0;
            state_q     <= S_SEARCH;
          end
        end
        S_SEARCH: begin
          if (hit_d) begin
            resp_pa_q    <= pa_d;
            resp_mat_q   <= mat_d;
            resp_exc_q   <= exc_d;
            resp_ecode_q <= ecode_d;
            resp_valid_q <= 1'b1;
            state_q      <= S_RESP;
          end else if (idx_q == IDXW'(TLBNUM - 1)) begin
            resp_pa_q    <= '0;
            resp_mat_q   <= '0;
            resp_exc_q   <= 1'b1;
            resp_ecode_q <= EC_TLBR;
            resp_valid_q <= 1'b1;
            state_q      <= S_RESP;
          end else begin
            idx_q <= idx_q + IDXW'(1);
          end
        end
        S_RESP: begin
          if (resp_ready_i) begin
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
            state_q      <= S_IDLE;
          end
        end
        default: begin
          state_q      <= S_IDLE;
          req_ready_q  <= 1'b1;
          resp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready_o  = req_ready_q;
  assign resp_valid_o = resp_valid_q;
  assign resp_pa_o    = resp_pa_q;
  assign resp_mat_o   = resp_mat_q;
  assign resp_exc_o   = resp_exc_q;
  assign resp_ecode_o = resp_ecode_q;

endmodule

// File: tb/tb_tlb_lookup_engine.sv
// Bench for tlb_lookup_engine: directed cases with literal expectations plus
// randomized traffic against a first-hit table-walk reference model.
module tb_tlb_lookup_engine;
  localparam int TLBNUM = 16;
  localparam int IDXW   = 4;

  logic            clk;
  logic            reset;
  logic            req_valid;
  logic            req_ready_o;
  logic [31:0]     req_va;
  logic [9:0]      req_asid;
  logic [1:0]      req_plv;
  logic [1:0]      req_op;
  logic            resp_valid_o;
  logic            resp_ready;
  logic [31:0]     resp_pa_o;
  logic [1:0]      resp_mat_o;
  logic            resp_exc_o;
  logic [5:0]      resp_ecode_o;
  logic            wr_en;
  logic [IDXW-1:0] wr_index;
  logic [83:0]     wr_data;
  logic            inv_all;
  logic [IDXW-1:0] rd_index;
  logic [83:0]     rd_data_o;

  tlb_lookup_engine #(.TLBNUM(TLBNUM)) dut (
    .clk_i(clk), .reset_i(reset),
    .req_valid_i(req_valid), .req_ready_o(req_ready_o),
    .req_va_i(req_va), .req_asid_i(req_asid), .req_plv_i(req_plv), .req_op_i(req_op),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready),
    .resp_pa_o(resp_pa_o), .resp_mat_o(resp_mat_o),
    .resp_exc_o(resp_exc_o), .resp_ecode_o(resp_ecode_o),
    .wr_en_i(wr_en), .wr_index_i(wr_index), .wr_data_i(wr_data),
    .inv_all_i(inv_all), .rd_index_i(rd_index), .rd_data_o(rd_data_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] pa;
    logic [1:0]  mat;
    logic        exc;
    logic [5:0]  ecode;
    bit          tlbr;
    int          k;
    int          c0;
    int          first_cyc;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        cur_e;
  logic [83:0] mtlb [TLBNUM];
  logic [18:0] pool [4];

  int n_cmp = 0;
  int n_bad = 0;

  // Filled in on each response handshake for the directed literal checks.
  logic [31:0] last_pa;
  logic [1:0]  last_mat;
  logic        last_exc;
  logic [5:0]  last_ecode;
  int          last_lat;
  int          last_vcyc;

  bit          seen_first = 0;
  bit          had_hs = 0;
  bit          prev_wait = 0;
  logic [40:0] prev_out;
  int          vcyc = 0;
  int          hold_cnt = 0;
  bit          rnd_ready = 0;

  task automatic chk(input string name, input logic [83:0] act, input logic [83:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [83:0] mk_ent(
      input logic e, input logic [18:0] vppn, input logic ps, input logic g, input logic [9:0] asid,
      input logic [19:0] ppn0, input logic [1:0] plv0, input logic [1:0] mat0, input logic d0, input logic v0,
      input logic [19:0] ppn1, input logic [1:0] plv1, input logic [1:0] mat1, input logic d1, input logic v1);
    return {e, vppn, ps, g, asid, ppn0, plv0, mat0, d0, v0, ppn1, plv1, mat1, d1, v1};
  endfunction

  // Reference translation: scan the whole table, first matching entry wins.
  function automatic exp_t model(input logic [31:0] va, input logic [9:0] asid,
                                 input logic [1:0] plv, input logic [1:0] op);
    exp_t        r;
    bit          found = 0;
    logic [83:0] ent;
    logic [83:0] sel = '0;
    logic        ps;
    logic [19:0] ppn;
    logic [1:0]  pplv;
    logic        pd;
    logic        pv;
    r.k = TLBNUM - 1;
    for (int i = 0; i < TLBNUM; i++) begin
      ent = mtlb[i];
      if (!found && ent[83] && (ent[62] || ent[61:52] == asid) &&
          (ent[63] ? (ent[82:73] == va[31:22]) : (ent[82:64] == va[31:13]))) begin
        found = 1;
        r.k   = i;
        sel   = ent;
      end
    end
    r.tlbr = !found;
    if (!found) begin
      r.pa = 32'h0; r.mat = 2'd0; r.exc = 1'b1; r.ecode = 6'h3F;
    end else begin
      ps = sel[63];
      if (ps ? va[21] : va[12]) begin
        ppn = sel[25:6];  pplv = sel[5:4];   r.mat = sel[3:2];   pd = sel[1];  pv = sel[0];
      end else begin
        ppn = sel[51:32]; pplv = sel[31:30]; r.mat = sel[29:28]; pd = sel[27]; pv = sel[26];
      end
      if (ps) r.pa = (32'(ppn) >> 10) * 32'h0040_0000 + (va & 32'h003F_FFFF);
      else    r.pa = 32'(ppn) * 32'h0000_1000 + (va & 32'h0000_0FFF);
      r.exc = 1'b1;
      if (!pv)                    r.ecode = (op == 2'd0) ? 6'h03 : (op == 2'd2) ? 6'h02 : 6'h01;
      else if (plv > pplv)        r.ecode = 6'h07;
      else if (op == 2'd2 && !pd) r.ecode = 6'h04;
      else begin r.exc = 1'b0; r.ecode = 6'h00; end
    end
    return r;
  endfunction

  // Per-cycle checker; also owns resp_ready.
  always @(negedge clk) begin
    if (reset) begin
      resp_ready = 1'b0;
      had_hs = 0; seen_first = 0; prev_wait = 0; vcyc = 0;
    end else begin
      if (had_hs) chk("req_ready_after_hs", 84'(req_ready_o), 84'(1));
      had_hs = 0;
      if (resp_valid_o) begin
        vcyc++;
        if (exp_q.size() == 0) begin
          chk("spurious_resp_valid", 84'(resp_valid_o), 84'(0));
          resp_ready = 1'b1;
        end else begin
          cur_e = exp_q[0];
          if (!seen_first) begin
            chk("latency", 84'(cyc), 84'(cur_e.first_cyc));
            last_lat = cyc - cur_e.c0 + 1;
            seen_first = 1;
          end
          chk("resp_pa", 84'(resp_pa_o), 84'(cur_e.pa));
          chk("resp_exc", 84'(resp_exc_o), 84'(cur_e.exc));
          chk("resp_ecode", 84'(resp_ecode_o), 84'(cur_e.ecode));
          if (!cur_e.tlbr) chk("resp_mat", 84'(resp_mat_o), 84'(cur_e.mat));
          chk("req_ready_in_resp", 84'(req_ready_o), 84'(0));
          if (prev_wait)
            chk("resp_stable", 84'({resp_pa_o, resp_mat_o, resp_exc_o, resp_ecode_o}), 84'(prev_out));
          prev_out = {resp_pa_o, resp_mat_o, resp_exc_o, resp_ecode_o};
          if (hold_cnt > 0) begin
            resp_ready = 1'b0;
            hold_cnt--;
          end else begin
            resp_ready = rnd_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
          end
          prev_wait = !resp_ready;
          if (resp_ready) begin
            last_pa = resp_pa_o; last_mat = resp_mat_o;
            last_exc = resp_exc_o; last_ecode = resp_ecode_o;
            last_vcyc = vcyc; vcyc = 0;
            void'(exp_q.pop_front());
            seen_first = 0;
            had_hs = 1;
          end
        end
      end else begin
        prev_wait = 0;
        resp_ready = 1'($urandom_range(0, 1));
        if (exp_q.size() > 0 && !seen_first && cyc > exp_q[0].first_cyc) begin
          chk("latency_late", 84'(cyc), 84'(exp_q[0].first_cyc));
          seen_first = 1;
        end
      end
    end
  end

  task automatic do_req(input logic [31:0] va, input logic [9:0] asid,
                        input logic [1:0] plv, input logic [1:0] op);
    exp_t r;
    int   n = 0;
    @(negedge clk);
    while (!req_ready_o && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready_o) begin
      chk("req_ready_timeout", 84'(req_ready_o), 84'(1));
      return;
    end
    req_va = va; req_asid = asid; req_plv = plv; req_op = op; req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    r = model(va, asid, plv, op);
    r.c0 = cyc;
    r.first_cyc = cyc + r.k + 1;
    exp_q.push_back(r);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && req_ready_o) return;
    end
    chk("idle_timeout", 84'(exp_q.size()), 84'(0));
    exp_q.delete();
  endtask

  task automatic wr_ent(input int idx, input logic [83:0] data, input bit do_wr, input bit do_inv);
    @(negedge clk);
    wr_en = do_wr; wr_index = IDXW'(idx); wr_data = data; inv_all = do_inv;
    @(posedge clk);
    #1;
    wr_en = 1'b0; inv_all = 1'b0;
    if (do_inv) begin
      for (int i = 0; i < TLBNUM; i++) mtlb[i][83] = 1'b0;
    end else if (do_wr) begin
      mtlb[idx] = data;
    end
  endtask

  task automatic chk_last(input string name, input logic [31:0] pa, input logic exc,
                          input logic [5:0] ec);
    chk({name, "_pa"}, 84'(last_pa), 84'(pa));
    chk({name, "_exc"}, 84'(last_exc), 84'(exc));
    chk({name, "_ecode"}, 84'(last_ecode), 84'(ec));
  endtask

  function automatic logic [83:0] rand_ent();
    logic [18:0] vp;
    vp = pool[$urandom_range(0, 3)];
    return mk_ent($urandom_range(0, 7) != 0, vp, $urandom_range(0, 3) == 0, 1'($urandom),
                  ($urandom_range(0, 1) != 0) ? 10'h001 : 10'h002,
                  20'($urandom), 2'($urandom), 2'($urandom), 1'($urandom), 1'($urandom_range(0, 3) != 0),
                  20'($urandom), 2'($urandom), 2'($urandom), 1'($urandom), 1'($urandom_range(0, 3) != 0));
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] va;
    logic [18:0] vp;
    pool[0] = 19'h00010; pool[1] = 19'h00200; pool[2] = 19'h7FE00; pool[3] = 19'h40000;
    for (int i = 0; i < TLBNUM; i++) mtlb[i] = '0;
    reset = 1'b1; req_valid = 1'b0; req_va = '0; req_asid = '0; req_plv = '0; req_op = '0;
    wr_en = 1'b0; wr_index = '0; wr_data = '0; inv_all = 1'b0; rd_index = '0; resp_ready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", 84'(req_ready_o), 84'(1));
    chk("rst_resp_valid", 84'(resp_valid_o), 84'(0));
    chk("rst_resp_fields", 84'({resp_pa_o, resp_mat_o, resp_exc_o, resp_ecode_o}), 84'(0));
    for (int i = 0; i < TLBNUM; i += 5) begin
      rd_index = IDXW'(i);
      #1;
      chk("rst_e_bit", 84'(rd_data_o[83]), 84'(0));
    end
    @(negedge clk);
    reset = 1'b0;

    // Empty table: full miss.
    do_req(32'h8000_0000, 10'h0, 2'd0, 2'd1);
    wait_idle();
    chk_last("miss", 32'h0, 1'b1, 6'h3F);
    chk("miss_latency", 84'(last_lat), 84'(TLBNUM + 1));

    // 4KB hit at index 5.
    wr_ent(5, mk_ent(1, 19'h00010, 0, 1, 10'h0, 20'h1234A, 2'd3, 2'd1, 1, 1, 20'h0, 2'd0, 2'd0, 0, 0), 1, 0);
    rd_index = 4'd5;
    #1;
    chk("rd_data_after_wr", rd_data_o, mtlb[5]);
    do_req(32'h0002_0ABC, 10'h0, 2'd3, 2'd1);
    wait_idle();
    chk_last("hit5", 32'h1234_AABC, 1'b0, 6'h00);
    chk("hit5_mat", 84'(last_mat), 84'(1));
    chk("hit5_latency", 84'(last_lat), 84'(7));

    // 4MB page, odd half, store.
    wr_ent(2, mk_ent(1, 19'h00200, 1, 1, 10'h0, 20'h0, 2'd0, 2'd0, 0, 0, 20'h00400, 2'd3, 2'd2, 1, 1), 1, 0);
    do_req(32'h0060_0010, 10'h0, 2'd0, 2'd2);
    wait_idle();
    chk_last("big", 32'h0060_0010, 1'b0, 6'h00);

    // Invalid / privilege / dirty exceptions on index 3.
    wr_ent(3, mk_ent(1, 19'h00100, 0, 1, 10'h0, 20'h55555, 2'd3, 2'd0, 1, 0, 20'h0, 2'd0, 2'd0, 0, 0), 1, 0);
    do_req(32'h0020_0000, 10'h0, 2'd0, 2'd0);
    wait_idle();
    chk("pif_ecode", 84'(last_ecode), 84'(6'h03));
    do_req(32'h0020_0000, 10'h0, 2'd0, 2'd2);
    wait_idle();
    chk("pis_ecode", 84'(last_ecode), 84'(6'h02));
    wr_ent(3, mk_ent(1, 19'h00100, 0, 1, 10'h0, 20'h55555, 2'd0, 2'd0, 1, 1, 20'h0, 2'd0, 2'd0, 0, 0), 1, 0);
    do_req(32'h0020_0000, 10'h0, 2'd3, 2'd1);
    wait_idle();
    chk("ppi_ecode", 84'(last_ecode), 84'(6'h07));
    wr_ent(3, mk_ent(1, 19'h00100, 0, 1, 10'h0, 20'h55555, 2'd3, 2'd0, 0, 1, 20'h0, 2'd0, 2'd0, 0, 0), 1, 0);
    do_req(32'h0020_0000, 10'h0, 2'd3, 2'd2);
    wait_idle();
    chk_last("pme", 32'h5555_5000, 1'b1, 6'h04);

    // ASID match, then invalidate-all.
    wr_ent(7, mk_ent(1, 19'h40300, 0, 0, 10'h011, 20'hABCDE, 2'd3, 2'd2, 1, 1, 20'h0, 2'd0, 2'd0, 0, 0), 1, 0);
    do_req(32'h8060_0123, 10'h012, 2'd0, 2'd1);
    wait_idle();
    chk("asid_miss_ecode", 84'(last_ecode), 84'(6'h3F));
    do_req(32'h8060_0123, 10'h011, 2'd0, 2'd1);
    wait_idle();
    chk_last("asid_hit", 32'hABCD_E123, 1'b0, 6'h00);
    wr_ent(0, '0, 0, 1);
    do_req(32'h8060_0123, 10'h011, 2'd0, 2'd1);
    wait_idle();
    chk("inv_ecode", 84'(last_ecode), 84'(6'h3F));
    wr_ent(9, mk_ent(1, 19'h00010, 0, 1, 10'h0, 20'h1, 2'd3, 2'd0, 1, 1, 20'h0, 2'd0, 2'd0, 0, 0), 1, 1);
    rd_index = 4'd9;
    #1;
    chk("inv_beats_wr", 84'(rd_data_o[83]), 84'(0));

    // Consumer back-pressure.
    wr_ent(5, mk_ent(1, 19'h00010, 0, 1, 10'h0, 20'h1234A, 2'd3, 2'd1, 1, 1, 20'h0, 2'd0, 2'd0, 0, 0), 1, 0);
    hold_cnt = 5;
    do_req(32'h0002_0ABC, 10'h0, 2'd3, 2'd1);
    wait_idle();
    chk("hold_valid_cycles", 84'(last_vcyc), 84'(6));
    chk_last("hold", 32'h1234_AABC, 1'b0, 6'h00);

    // Randomized traffic with random back-pressure and back-to-back requests.
    rnd_ready = 1;
    for (int i = 0; i < TLBNUM; i++) wr_ent(i, rand_ent(), 1, 0);
    for (int t = 0; t < 250; t++) begin
      if ($urandom_range(0, 9) == 0) begin
        wait_idle();
        wr_ent($urandom_range(0, TLBNUM - 1), rand_ent(), 1, $urandom_range(0, 19) == 0);
      end else begin
        vp = pool[$urandom_range(0, 3)];
        case ($urandom_range(0, 3))
          0:       va = $urandom;
          1:       va = {vp[18:9], 22'($urandom)};
          default: va = {vp, 13'($urandom)};
        endcase
        do_req(va, ($urandom_range(0, 1) != 0) ? 10'h001 : 10'h002,
               ($urandom_range(0, 1) != 0) ? 2'd3 : 2'd0, 2'($urandom));
      end
    end
    wait_idle();
    rnd_ready = 0;

    // Reset while searching aborts the transaction.
    wr_ent(0, '0, 0, 1);
    do_req(32'h8000_0000, 10'h0, 2'd0, 2'd1);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    exp_q.delete();
    for (int i = 0; i < TLBNUM; i++) mtlb[i][83] = 1'b0;
    #1;
    chk("rst_mid_resp_valid", 84'(resp_valid_o), 84'(0));
    chk("rst_mid_req_ready", 84'(req_ready_o), 84'(1));
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    chk("post_rst_resp_valid", 84'(resp_valid_o), 84'(0));
    chk("post_rst_req_ready", 84'(req_ready_o), 84'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
